hamming_secded_decoder: RTL

HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

---
 rtl/hamming_secded_decoder.sv | 83 ++++++++
 1 files changed

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder: two-stage extended-Hamming SECDED decoder with
// valid/ready flow control and saturating corrected/uncorrected error counters.
module hamming_secded_decoder #(
    parameter int R = 5,
    parameter int CNT_W = 16,
    localparam int CW = 2 ** R,
    localparam int K = CW - 1 - R
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    code_in,
    input  logic             correct_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     data_out,
    output logic [R-1:0]     err_pos,
    output logic             single_err,
    output logic             double_err,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt,
    input  logic             cnt_clr
);
    logic [R-1:0] syn, s1_s;
    logic [K-1:0] raw, s1_data, data_nxt;
    logic par, s1_p, s1_ce, s1_valid, advance, xfer, flip;

    always_comb begin
        syn = '0;
        for (int i = 1; i < CW; i++) syn = code_in[i] ? syn ^ R'(i) : syn;
    end

    assign par = ^code_in;
    assign advance = !out_valid || out_ready;
    assign in_ready = advance || !s1_valid;
    assign xfer = out_valid && out_ready;
    assign flip = s1_p && s1_s != '0 && s1_ce;

    // Only data-bearing positions are carried past stage 1; a flip of a
    // check-bit position never reaches data_out, so it needs no storage.
    for (genvar i = 3; i < CW; i++) begin : g_d
        if ((i & (i - 1)) != 0) begin : g_b
            localparam int J = i - 1 - $clog2(i + 1);
            assign raw[J] = code_in[i];
            assign data_nxt[J] = s1_data[J] ^ (flip && s1_s == R'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data <= '0;
            s1_s <= '0;
            s1_p <= 1'b0;
            s1_ce <= 1'b0;
            out_valid <= 1'b0;
            data_out <= '0;
            err_pos <= '0;
            single_err <= 1'b0;
            double_err <= 1'b0;
            corr_cnt <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                s1_data <= raw;
                s1_s <= syn;
                s1_p <= par;
                s1_ce <= correct_en;
            end
            if (advance) begin
                out_valid <= s1_valid;
                data_out <= data_nxt;
                err_pos <= s1_s;
                single_err <= s1_valid && s1_p;
                double_err <= s1_valid && !s1_p && s1_s != '0;
            end
            corr_cnt <= cnt_clr ? '0 : (xfer && single_err && corr_cnt != '1) ? corr_cnt + CNT_W'(1) : corr_cnt;
            uncorr_cnt <= cnt_clr ? '0 : (xfer && double_err && uncorr_cnt != '1) ? uncorr_cnt + CNT_W'(1) : uncorr_cnt;
        end
    end
endmodule
